alu_ctrl_seq: RTL and testbench

Parametrised ALU control unit with an integrated multi-cycle unsigned multiplier sequencer. It sits between the main control unit and the single-cycle ALU. It decodes `ALU_op`/`Funct_ctrl` into a widened 3-bit ALU function select covering add, sub, sll, srl, or, and and slt. For `multu` it runs a shift-add state machine, stalls the pipeline for the whole operation, and writes the 2×`DATA_W` product into internal HI/LO registers.

---
 rtl/alu_ctrl_seq.sv | 115 +++++++++++
 tb/tb_alu_ctrl_seq.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// ALU function-select decoder with an attached shift-add unsigned multiplier (multu).
// The pipeline is stalled while a multiply runs; the product lands in HI/LO.
module alu_ctrl_seq #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_i,
   input  logic              flush,
   input  logic [1:0]        ALU_op,
   input  logic [5:0]        Funct_ctrl,
   input  logic [DATA_W-1:0] src_a,
   input  logic [DATA_W-1:0] src_b,
   output logic [2:0]        Funct,
   output logic              illegal,
   output logic              stall,
   output logic              mul_done,
   output logic [DATA_W-1:0] mul_hi,
   output logic [DATA_W-1:0] mul_lo
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t                state_reg;
   logic [2*DATA_W-1:0]   mcand_reg;
   logic [2*DATA_W-1:0]   prod_reg;
   logic [2*DATA_W-1:0]   prod_next;
   logic [DATA_W-1:0]     mplier_reg;
   logic [CNT_W-1:0]      cnt_reg;

   logic                  is_multu;
   logic [2:0]            dec_funct;
   logic                  dec_illegal;
   logic                  accept;
   logic                  last_iter;

   always_comb begin
      dec_funct   = 3'd7;
      dec_illegal = 1'b0;
      is_multu    = 1'b0;
      case (ALU_op)
         2'b00: dec_funct = 3'd1;
         2'b01: dec_funct = 3'd0;
         2'b11: dec_funct = 3'd3;
         default: begin
            case (Funct_ctrl)
               6'b100001: dec_funct = 3'd0;
               6'b100011: dec_funct = 3'd1;
               6'b000000: dec_funct = 3'd2;
               6'b100101: dec_funct = 3'd3;
               6'b000010: dec_funct = 3'd4;
               6'b101010: dec_funct = 3'd5;
               6'b100100: dec_funct = 3'd6;
               6'b011001: is_multu  = 1'b1;
               default:   dec_illegal = 1'b1;
            endcase
         end
      endcase
   end

   // While a multiply is in flight the ALU is idle, so report "none".
   assign Funct   = (state_reg == IDLE) ? dec_funct : 3'd7;
   assign illegal = (state_reg == IDLE) ? dec_illegal : 1'b0;

   assign accept    = (state_reg == IDLE) && valid_i && is_multu && !flush;
   assign stall     = accept || (state_reg == MUL);
   assign last_iter = (cnt_reg == CNT_W'(DATA_W - 1));
   assign prod_next = prod_reg + (mplier_reg[0] ? mcand_reg : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         mcand_reg  <= '0;
         prod_reg   <= '0;
         mplier_reg <= '0;
         cnt_reg    <= '0;
         mul_done   <= 1'b0;
         mul_hi     <= '0;
         mul_lo     <= '0;
      end else begin
         mul_done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  mcand_reg  <= {{DATA_W{1'b0}}, src_a};
                  mplier_reg <= src_b;
                  prod_reg   <= '0;
                  cnt_reg    <= '0;
                  state_reg  <= MUL;
               end
            end
            MUL: begin
               // Flush wins over completion: HI/LO stay untouched.
               if (flush) begin
                  state_reg <= IDLE;
               end else begin
                  prod_reg   <= prod_next;
                  mcand_reg  <= mcand_reg << 1;
                  mplier_reg <= mplier_reg >> 1;
                  cnt_reg    <= cnt_reg + CNT_W'(1);
                  if (last_iter) begin
                     {mul_hi, mul_lo} <= prod_next;
                     mul_done         <= 1'b1;
                     state_reg        <= DONE;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: decode table, multu timing/results, flush and reset.
// A second instance with DATA_W=8 covers the narrow-width case.
module tb_alu_ctrl_seq;

   logic        clk;
   logic        rst_n;
   logic        valid_i;
   logic        flush;
   logic [1:0]  ALU_op;
   logic [5:0]  Funct_ctrl;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic [2:0]  Funct;
   logic        illegal;
   logic        stall;
   logic        mul_done;
   logic [31:0] mul_hi;
   logic [31:0] mul_lo;

   logic        valid8;
   logic [7:0]  src_a8;
   logic [7:0]  src_b8;
   logic [2:0]  funct8;
   logic        illegal8;
   logic        stall8;
   logic        done8;
   logic [7:0]  hi8;
   logic [7:0]  lo8;

   int total;
   int bad;

   alu_ctrl_seq #(.DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .flush(flush),
      .ALU_op(ALU_op), .Funct_ctrl(Funct_ctrl), .src_a(src_a), .src_b(src_b),
      .Funct(Funct), .illegal(illegal), .stall(stall), .mul_done(mul_done),
      .mul_hi(mul_hi), .mul_lo(mul_lo)
   );

   alu_ctrl_seq #(.DATA_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .valid_i(valid8), .flush(flush),
      .ALU_op(ALU_op), .Funct_ctrl(Funct_ctrl), .src_a(src_a8), .src_b(src_b8),
      .Funct(funct8), .illegal(illegal8), .stall(stall8), .mul_done(done8),
      .mul_hi(hi8), .mul_lo(lo8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; valid_i = 1'b0; flush = 1'b0; ALU_op = 2'b01; Funct_ctrl = 6'd0;
      src_a = '0; src_b = '0; valid8 = 1'b0; src_a8 = '0; src_b8 = '0;
      #2;
      step();
      total++;
      if (stall !== 1'b0 || mul_done !== 1'b0 || mul_hi !== 32'd0 || mul_lo !== 32'd0) begin
         bad++;
         $display("FAIL reset_outputs: stall=%b done=%b hi=%h lo=%h, required 0 0 0 0",
                  stall, mul_done, mul_hi, mul_lo);
      end
      total++;
      if (Funct !== 3'd0) begin
         bad++;
         $display("FAIL reset_idle_decode: Funct=%0d, required 0", Funct);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      $display("reset released: stall=%b done=%b", stall, mul_done);
   endtask

   task automatic test_decode();
      logic [5:0] codes [7];
      logic [2:0] r_exp [7];
      logic [2:0] expf;
      codes = '{6'b100001, 6'b100011, 6'b000000, 6'b100101, 6'b000010, 6'b101010, 6'b100100};
      r_exp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
      valid_i = 1'b0;
      for (int op = 0; op < 4; op++) begin
         for (int k = 0; k < 7; k++) begin
            ALU_op = 2'(op);
            Funct_ctrl = codes[k];
            #1;
            case (op)
               0: expf = 3'd1;
               1: expf = 3'd0;
               3: expf = 3'd3;
               default: expf = r_exp[k];
            endcase
            total++;
            if (Funct !== expf || illegal !== 1'b0) begin
               bad++;
               $display("FAIL decode op=%0d funct=%b: Funct=%0d illegal=%b, required %0d 0",
                        op, codes[k], Funct, illegal, expf);
            end
         end
      end
      ALU_op = 2'b10; Funct_ctrl = 6'b000111; #1;
      total++;
      if (Funct !== 3'd7 || illegal !== 1'b1) begin
         bad++;
         $display("FAIL decode_illegal: Funct=%0d illegal=%b, required 7 1", Funct, illegal);
      end
      Funct_ctrl = 6'b011001; #1;
      total++;
      if (Funct !== 3'd7 || illegal !== 1'b0 || stall !== 1'b0) begin
         bad++;
         $display("FAIL decode_multu_novalid: Funct=%0d illegal=%b stall=%b, required 7 0 0",
                  Funct, illegal, stall);
      end
      $display("decode sweep done");
   endtask

   // Called in IDLE; returns one cycle after DONE, back in IDLE with valid_i low.
   task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int stall_cnt;
      int done_cyc;
      valid_i = 1'b1; ALU_op = 2'b10; Funct_ctrl = 6'b011001; src_a = a; src_b = b;
      #1;
      total++;
      if (stall !== 1'b1) begin
         bad++;
         $display("FAIL %s accept_stall: stall=%b, required 1", name, stall);
      end
      stall_cnt = (stall === 1'b1) ? 1 : 0;
      done_cyc = -1;
      for (int c = 1; c <= 40; c++) begin
         step();
         if (mul_done === 1'b1) begin
            done_cyc = c;
            break;
         end
         if (stall === 1'b1) stall_cnt++;
         if (c == 5) begin
            total++;
            if (Funct !== 3'd7) begin
               bad++;
               $display("FAIL %s busy_funct: Funct=%0d, required 7", name, Funct);
            end
         end
      end
      total++;
      if (done_cyc != 33 || stall_cnt != 33) begin
         bad++;
         $display("FAIL %s timing: done_cycle=%0d stall_cycles=%0d, required 33 33",
                  name, done_cyc, stall_cnt);
      end
      total++;
      if (mul_hi !== exp_hi || mul_lo !== exp_lo || stall !== 1'b0) begin
         bad++;
         $display("FAIL %s product: hi=%h lo=%h stall=%b, required %h %h 0",
                  name, mul_hi, mul_lo, stall, exp_hi, exp_lo);
      end
      $display("%s: %h x %h -> hi=%h lo=%h done_cycle=%0d stalls=%0d",
               name, a, b, mul_hi, mul_lo, done_cyc, stall_cnt);
      valid_i = 1'b0;
      step();
      total++;
      if (mul_done !== 1'b0 || mul_hi !== exp_hi || mul_lo !== exp_lo) begin
         bad++;
         $display("FAIL %s hold: done=%b hi=%h lo=%h, required 0 %h %h",
                  name, mul_done, mul_hi, mul_lo, exp_hi, exp_lo);
      end
   endtask

   task automatic test_back_to_back();
      run_mul("mul_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      run_mul("mul_b2b", 32'd2, 32'd7, 32'd0, 32'd14);
   endtask

   // Starts a multu and flushes it in MUL cycle flush_cyc; HI/LO must keep 0/14.
   task automatic flush_at(input string name, input int flush_cyc);
      logic seen_done;
      valid_i = 1'b1; ALU_op = 2'b10; Funct_ctrl = 6'b011001; src_a = 32'd9; src_b = 32'd9;
      step();
      valid_i = 1'b0;
      for (int c = 1; c < flush_cyc; c++) step();
      flush = 1'b1;
      #1;
      total++;
      if (stall !== 1'b1) begin
         bad++;
         $display("FAIL %s pre_flush_stall: stall=%b, required 1", name, stall);
      end
      step();
      flush = 1'b0;
      ALU_op = 2'b01;
      #1;
      total++;
      if (stall !== 1'b0 || mul_done !== 1'b0 || Funct !== 3'd0) begin
         bad++;
         $display("FAIL %s post_flush: stall=%b done=%b Funct=%0d, required 0 0 0",
                  name, stall, mul_done, Funct);
      end
      seen_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         step();
         if (mul_done === 1'b1) seen_done = 1'b1;
      end
      total++;
      if (seen_done !== 1'b0 || mul_hi !== 32'd0 || mul_lo !== 32'd14) begin
         bad++;
         $display("FAIL %s no_update: done_seen=%b hi=%h lo=%h, required 0 0 e",
                  name, seen_done, mul_hi, mul_lo);
      end
      $display("%s: flushed at MUL cycle %0d, hi=%h lo=%h", name, flush_cyc, mul_hi, mul_lo);
   endtask

   task automatic test_flush();
      flush_at("flush_c10", 10);
      flush_at("flush_last", 32);
      valid_i = 1'b1; ALU_op = 2'b10; Funct_ctrl = 6'b011001; flush = 1'b1;
      #1;
      total++;
      if (stall !== 1'b0) begin
         bad++;
         $display("FAIL flush_idle_stall: stall=%b, required 0", stall);
      end
      step();
      valid_i = 1'b0; flush = 1'b0; ALU_op = 2'b00;
      #1;
      total++;
      if (stall !== 1'b0 || Funct !== 3'd1) begin
         bad++;
         $display("FAIL flush_idle_noaccept: stall=%b Funct=%0d, required 0 1", stall, Funct);
      end
      $display("flush in IDLE: stall=%b Funct=%0d", stall, Funct);
   endtask

   task automatic test_reset_mid();
      valid_i = 1'b1; ALU_op = 2'b10; Funct_ctrl = 6'b011001; src_a = 32'd4; src_b = 32'd4;
      step();
      valid_i = 1'b0;
      repeat (4) step();
      rst_n = 1'b0;
      ALU_op = 2'b01;
      #1;
      total++;
      if (stall !== 1'b0 || mul_done !== 1'b0 || mul_hi !== 32'd0 || mul_lo !== 32'd0
          || Funct !== 3'd0) begin
         bad++;
         $display("FAIL reset_mid: stall=%b done=%b hi=%h lo=%h Funct=%0d, required 0 0 0 0 0",
                  stall, mul_done, mul_hi, mul_lo, Funct);
      end
      step();
      @(negedge clk);
      rst_n = 1'b1;
      $display("reset mid-MUL: hi=%h lo=%h stall=%b", mul_hi, mul_lo, stall);
      step();
      run_mul("mul_after_rst", 32'd3, 32'd5, 32'd0, 32'd15);
   endtask

   task automatic test_width8();
      int done_cyc;
      valid8 = 1'b1; ALU_op = 2'b10; Funct_ctrl = 6'b011001; src_a8 = 8'hFF; src_b8 = 8'h02;
      #1;
      total++;
      if (stall8 !== 1'b1) begin
         bad++;
         $display("FAIL w8_accept: stall=%b, required 1", stall8);
      end
      done_cyc = -1;
      for (int c = 1; c <= 20; c++) begin
         step();
         valid8 = 1'b0;
         if (done8 === 1'b1) begin
            done_cyc = c;
            break;
         end
      end
      total++;
      if (done_cyc != 9 || hi8 !== 8'h01 || lo8 !== 8'hFE) begin
         bad++;
         $display("FAIL w8_mul: done_cycle=%0d hi=%h lo=%h, required 9 01 fe",
                  done_cyc, hi8, lo8);
      end
      $display("w8 mul: ff x 02 -> hi=%h lo=%h done_cycle=%0d", hi8, lo8, done_cyc);
      step();
   endtask

   initial begin
      total = 0;
      bad = 0;
      test_reset();
      test_decode();
      run_mul("mul_3x5", 32'd3, 32'd5, 32'd0, 32'd15);
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_width8();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
